track_sequencer: RTL and testbench

TRACK_SEQUENCER -- requirements
Module: track_sequencer

---
 rtl/track_sequencer_pkg.sv | 15 +
 rtl/track_smoother.sv | 22 ++
 rtl/track_sequencer.sv | 148 ++++++++++++++
 tb/tb_track_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/track_sequencer_pkg.sv
// Shared definitions for the track sequencer: state encoding, coordinate widths
// and default frame geometry.
package track_sequencer_pkg;
  localparam int X_W            = 10;
  localparam int Y_W            = 9;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_MEASURE  = 2'd2,
    ST_EVAL     = 2'd3
  } state_t;
endpackage

// File: rtl/track_smoother.sv
// One axis of the target smoothing filter: next = cur + ((new - cur) >>> SHIFT),
// computed on a one-bit-wider signed difference.
module track_smoother #(
  parameter int W       = 10,
  parameter int SHIFT   = 2,
  parameter int MAX_VAL = 639
) (
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_new,
  output logic [W-1:0] o_next
);
  logic signed [W:0] w_diff;
  logic signed [W:0] w_step;
  logic signed [W:0] w_sum;

  assign w_diff = $signed({1'b0, i_new}) - $signed({1'b0, i_cur});
  assign w_step = w_diff >>> SHIFT;
  assign w_sum  = $signed({1'b0, i_cur}) + w_step;

  // The sum stays between cur and new; the clamp only guards the frame edge.
  assign o_next = (w_sum > MAX_VAL) ? W'(MAX_VAL) : W'($unsigned(w_sum));
endmodule

// File: rtl/track_sequencer.sv
// Frame-by-frame tracking sequencer: arms the centroid measurement per frame,
// qualifies hits/misses into a lock flag and emits a smoothed target stream.
module track_sequencer
  import track_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH      = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT     = DEF_IMG_HEIGHT,
  parameter int LOCK_FRAMES    = 3,
  parameter int LOSE_FRAMES    = 5,
  parameter int SMOOTH_SHIFT   = 2,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_enable,
  input  logic           i_sof,
  output logic           o_arm,
  input  logic           i_res_end,
  input  logic           i_res_found,
  input  logic [X_W-1:0] i_res_x,
  input  logic [Y_W-1:0] i_res_y,
  output logic           o_tgt_valid,
  input  logic           i_tgt_ready,
  output logic [X_W-1:0] o_tgt_x,
  output logic [Y_W-1:0] o_tgt_y,
  output logic           o_locked,
  output logic [1:0]     o_state,
  output logic           o_drop
);
  localparam int HIT_W  = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W = $clog2(LOSE_FRAMES + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state, w_next;
  logic [WD_W-1:0]    r_wdog;
  logic               r_found;
  logic [X_W-1:0]     r_res_x, r_tgt_x, w_sm_x;
  logic [Y_W-1:0]     r_res_y, r_tgt_y, w_sm_y;
  logic [HIT_W-1:0]   r_hit, w_hit_nxt;
  logic [MISS_W-1:0]  r_miss, w_miss_nxt;
  logic               r_locked, w_lock_nxt;
  logic               r_tgt_valid, r_drop;
  logic               w_eval, w_new_tgt, w_wd_tc;

  assign w_eval  = (r_state == ST_EVAL);
  assign w_wd_tc = (r_wdog == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_enable) w_next = ST_WAIT_SOF;
      ST_WAIT_SOF: if (!i_enable) w_next = ST_IDLE;
                   else if (i_sof) w_next = ST_MEASURE;
      ST_MEASURE:  if (i_res_end || w_wd_tc) w_next = ST_EVAL;
      ST_EVAL:     w_next = i_enable ? ST_WAIT_SOF : ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_hit_nxt  = '0;
    w_miss_nxt = '0;
    if (r_found)
      w_hit_nxt = (r_hit == HIT_W'(LOCK_FRAMES)) ? r_hit : r_hit + 1'b1;
    else
      w_miss_nxt = (r_miss == MISS_W'(LOSE_FRAMES)) ? r_miss : r_miss + 1'b1;
    w_lock_nxt = r_locked;
    if (w_hit_nxt == HIT_W'(LOCK_FRAMES))
      w_lock_nxt = 1'b1;
    if (w_miss_nxt == MISS_W'(LOSE_FRAMES))
      w_lock_nxt = 1'b0;
  end

  assign w_new_tgt = w_eval && w_lock_nxt;

  track_smoother #(.W(X_W), .SHIFT(SMOOTH_SHIFT), .MAX_VAL(IMG_WIDTH - 1)) u_smooth_x (
    .i_cur (r_tgt_x),
    .i_new (r_res_x),
    .o_next(w_sm_x)
  );

  track_smoother #(.W(Y_W), .SHIFT(SMOOTH_SHIFT), .MAX_VAL(IMG_HEIGHT - 1)) u_smooth_y (
    .i_cur (r_tgt_y),
    .i_new (r_res_y),
    .o_next(w_sm_y)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_wdog      <= '0;
      r_found     <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
      r_locked    <= 1'b0;
      r_tgt_x     <= '0;
      r_tgt_y     <= '0;
      r_tgt_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= 1'b0;

      if (r_state == ST_WAIT_SOF && i_enable && i_sof)
        r_wdog <= WD_W'(TIMEOUT_CYCLES - 1);
      else if (r_state == ST_MEASURE && !w_wd_tc)
        r_wdog <= r_wdog - 1'b1;

      // A result strobe on the watchdog's last cycle still wins over the forced miss.
      if (r_state == ST_MEASURE) begin
        if (i_res_end) begin
          r_found <= i_res_found;
          r_res_x <= i_res_x;
          r_res_y <= i_res_y;
        end else if (w_wd_tc) begin
          r_found <= 1'b0;
        end
      end

      if (w_eval) begin
        r_hit    <= w_hit_nxt;
        r_miss   <= w_miss_nxt;
        r_locked <= w_lock_nxt;
        if (r_found && w_lock_nxt) begin
          r_tgt_x <= r_locked ? w_sm_x : r_res_x;
          r_tgt_y <= r_locked ? w_sm_y : r_res_y;
        end
      end

      if (w_new_tgt) begin
        r_tgt_valid <= 1'b1;
        r_drop      <= r_tgt_valid && !i_tgt_ready;
      end else if (r_tgt_valid && i_tgt_ready) begin
        r_tgt_valid <= 1'b0;
      end
    end
  end

  assign o_arm       = (r_state == ST_MEASURE);
  assign o_state     = r_state;
  assign o_locked    = r_locked;
  assign o_tgt_valid = r_tgt_valid;
  assign o_tgt_x     = r_tgt_x;
  assign o_tgt_y     = r_tgt_y;
  assign o_drop      = r_drop;
endmodule

// File: tb/tb_track_sequencer.sv
// Randomized bench for track_sequencer: frames are driven through a small
// transaction task and outputs compared against an arithmetic reference model.
module tb_track_sequencer;
  localparam int LOCK = 3;
  localparam int LOSE = 5;
  localparam int SHF  = 2;
  localparam int TMO  = 40;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_sof = 1'b0;
  logic       o_arm;
  logic       i_res_end = 1'b0;
  logic       i_res_found = 1'b0;
  logic [9:0] i_res_x = '0;
  logic [8:0] i_res_y = '0;
  logic       o_tgt_valid;
  logic       i_tgt_ready = 1'b0;
  logic [9:0] o_tgt_x;
  logic [8:0] o_tgt_y;
  logic       o_locked;
  logic [1:0] o_state;
  logic       o_drop;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  int m_hit, m_miss, m_tx, m_ty;
  bit m_locked, m_pending;

  track_sequencer #(
    .IMG_WIDTH(640), .IMG_HEIGHT(480), .LOCK_FRAMES(LOCK), .LOSE_FRAMES(LOSE),
    .SMOOTH_SHIFT(SHF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_sof(i_sof), .o_arm(o_arm),
    .i_res_end(i_res_end), .i_res_found(i_res_found), .i_res_x(i_res_x), .i_res_y(i_res_y),
    .o_tgt_valid(o_tgt_valid), .i_tgt_ready(i_tgt_ready), .o_tgt_x(o_tgt_x),
    .o_tgt_y(o_tgt_y), .o_locked(o_locked), .o_state(o_state), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int smooth(input int t, input int n);
    int d, q, den;
    den = 1 << SHF;
    d = n - t;
    q = d / den;
    if (d < 0 && (d % den) != 0) q = q - 1;
    return t + q;
  endfunction

  task automatic model_reset();
    m_hit = 0; m_miss = 0; m_tx = 0; m_ty = 0; m_locked = 0; m_pending = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, o_state, 0);
    check({tag, "_arm"}, o_arm, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_valid"}, o_tgt_valid, 0);
    check({tag, "_drop"}, o_drop, 0);
    check({tag, "_tx"}, o_tgt_x, 0);
    check({tag, "_ty"}, o_tgt_y, 0);
  endtask

  task automatic wait_wsof();
    int n = 0;
    while (o_state != 2'd1 && n < 10) begin
      step();
      n++;
    end
    check("wait_sof_reached", o_state, 1);
  endtask

  // ready_mode: 0 = ready low, 1 = ready high whole frame, 2 = ready high only at the eval edge
  task automatic run_frame(input bit found, input int x, input int y, input int ready_mode,
                           input bit timeout, input bit en_off);
    bit was, new_t, exp_drop, rdy_c;
    int n;
    wait_wsof();
    i_sof = 1'b1;
    i_tgt_ready = (ready_mode == 1);
    if (ready_mode == 1) m_pending = 0;
    step();
    i_sof = 1'b0;
    check("measure_arm", o_arm, 1);
    check("measure_state", o_state, 2);
    check("drop_idle", o_drop, 0);
    if (en_off) i_enable = 1'b0;
    if (timeout) begin
      n = 1;
      while (o_state == 2'd2 && n < TMO + 10) begin
        step();
        if (o_state == 2'd2) n++;
      end
      check("timeout_len", n, TMO);
      found = 0;
    end else begin
      repeat ($urandom_range(0, 5)) step();
      i_res_end = 1'b1;
      i_res_found = found;
      i_res_x = 10'(x);
      i_res_y = 9'(y);
      step();
      i_res_end = 1'b0;
      i_res_x = 10'($urandom_range(0, 639));
      i_res_y = 9'($urandom_range(0, 479));
    end
    check("eval_state", o_state, 3);
    check("eval_arm", o_arm, 0);
    if (ready_mode == 2) i_tgt_ready = 1'b1;
    rdy_c = i_tgt_ready;
    step();
    // reference update
    if (found) begin
      m_hit = (m_hit + 1 > LOCK) ? LOCK : m_hit + 1;
      m_miss = 0;
    end else begin
      m_miss = (m_miss + 1 > LOSE) ? LOSE : m_miss + 1;
      m_hit = 0;
    end
    was = m_locked;
    if (m_hit == LOCK) m_locked = 1;
    if (m_miss == LOSE) m_locked = 0;
    if (found && m_locked) begin
      if (!was) begin m_tx = x; m_ty = y; end
      else begin m_tx = smooth(m_tx, x); m_ty = smooth(m_ty, y); end
    end
    new_t = m_locked;
    exp_drop = 0;
    if (new_t) begin
      exp_drop = m_pending && !rdy_c;
      m_pending = 1;
    end else if (rdy_c) begin
      m_pending = 0;
    end
    check("locked", o_locked, m_locked);
    check("tgt_valid", o_tgt_valid, m_pending);
    check("drop", o_drop, exp_drop);
    check("tgt_x", o_tgt_x, m_tx);
    check("tgt_y", o_tgt_y, m_ty);
    check("post_eval_state", o_state, i_enable ? 1 : 0);
    i_tgt_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    check_all_zero("reset");
    i_rstn = 1'b1;
    step();
    check("idle_hold", o_state, 0);
    i_enable = 1'b1;
    step();
    check("idle_to_wsof", o_state, 1);

    // result strobe outside MEASURE must be ignored
    i_res_end = 1'b1; i_res_found = 1'b1;
    step();
    i_res_end = 1'b0;
    check("stray_res_end", o_state, 1);

    // acquire lock at (100,50)
    run_frame(1, 100, 50, 1, 0, 0);
    run_frame(1, 100, 50, 1, 0, 0);
    run_frame(1, 100, 50, 0, 0, 0);
    check("lock_x", o_tgt_x, 100);
    check("lock_y", o_tgt_y, 50);
    // smoothed hit while previous target unconsumed -> (110,40) and a drop
    run_frame(1, 140, 10, 0, 0, 0);
    check("smooth_x", o_tgt_x, 110);
    check("smooth_y", o_tgt_y, 40);
    check("drop_pulse", o_drop, 1);
    // acceptance coincident with a new target: no drop
    run_frame(1, 300, 200, 2, 0, 0);
    // disable during MEASURE completes the frame, then IDLE
    run_frame(1, 320, 220, 1, 0, 1);
    check("en_off_idle", o_state, 0);
    i_enable = 1'b1;
    // five misses drop lock
    repeat (LOSE) run_frame(0, 0, 0, 1, 0, 0);
    check("lost_lock", o_locked, 0);
    // watchdog-forced miss
    run_frame(1, 10, 10, 1, 1, 0);

    // reset in the middle of a frame
    wait_wsof();
    i_sof = 1'b1;
    step();
    i_sof = 1'b0;
    check("pre_rst_measure", o_state, 2);
    i_rstn = 1'b0;
    step();
    check_all_zero("mid_rst");
    i_rstn = 1'b1;
    model_reset();

    for (int i = 0; i < 80; i++) begin
      run_frame($urandom_range(0, 9) < 7, $urandom_range(0, 639), $urandom_range(0, 479),
                $urandom_range(0, 2), $urandom_range(0, 19) == 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
